// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-addressed 64-bit data memory between instruction fetch and load/store.
// Each access runs IDLE -> ACCESS -> RESP. Data wins ties unless fetch has been starved too long.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned MEM_BYTES  = 128,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_valid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_data_out
);

  localparam int unsigned   CW        = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STARVE_MAX);
  localparam logic [63:0]   ADDR_LAST = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          lat_data, lat_we;
  logic [63:0]   lat_addr, lat_wdata;
  logic [CW-1:0] starve_cnt;
  logic          if_err_q, d_err_q;
  logic [63:0]   if_rdata_q, d_rdata_q;
  logic          grant_data, in_range;

  // Unsigned compare against the last legal base also rejects addresses where addr + 7 wraps.
  assign in_range   = (lat_addr <= ADDR_LAST);
  assign grant_data = d_req && !(if_req && (starve_cnt == CNT_MAX));

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_data   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!if_req)                                starve_cnt <= '0;
          else if (!grant_data)                       starve_cnt <= '0;
          else if (d_req && (starve_cnt != CNT_MAX))  starve_cnt <= starve_cnt + CW'(1);
          if (if_req || d_req) begin
            lat_data  <= grant_data;
            lat_addr  <= grant_data ? d_addr : if_addr;
            lat_we    <= grant_data && d_we;
            lat_wdata <= grant_data ? d_wdata : '0;
          end
        end
        ACCESS: begin
          if (lat_data) begin
            d_err_q <= !in_range;
            if (!in_range)    d_rdata_q <= '0;
            else if (!lat_we) d_rdata_q <= mem_data_out;
          end else begin
            if_err_q   <= !in_range;
            if_rdata_q <= in_range ? mem_data_out : '0;
          end
        end
        RESP: begin
          if_err_q <= 1'b0;
          d_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_address = lat_addr;
  assign mem_data_in = lat_wdata;
  assign mem_read    = (state_q == ACCESS) && in_range && !lat_we;
  assign mem_write   = (state_q == ACCESS) && in_range && lat_we;

  assign if_valid = (state_q == RESP) && !lat_data;
  assign d_valid  = (state_q == RESP) && lat_data;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_err   = if_err_q;
  assign d_err    = d_err_q;

endmodule
